fru_mc: RTL
===========

Name: fru_mc

Overview:
- Multi-context successor to the single-config FRU.
- Holds NCTX independently loadable override contexts. Each context has a mask, a constant and a hold time.
- Contexts are programmed through an XOR-decrypted, parity-checked serial frame.
- A per-context trigger selects the active context, which overrides selected bits of the controlled signal set with a registered output. The block sits between the SMU trigger outputs and the patched signals.

Parameters:
- N, 32, width of controlled signal set Qin/Qout
- NCTX, 4, number of contexts (≥2)
- HOLD_W, 4, hold-counter width
- KEY_W, 32, decrypt key width
- DECRYPT_KEY, 32'hDEAD_BEEF, XOR keystream seed

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- BitStreamSerialIn  in  1  serial cfg bit, MSB first
- BitStreamValid  in  1  qualifies BitStreamSerialIn
- GlobalFruEn  in  1  0 forces passthrough
- Trig  in  NCTX  Trig[i] requests context i
- Qin  in  N  controllable signal set input
- Qout  out  N  patched output, registered
- CtxValid  out  NCTX  context i holds a committed cfg
- BitstreamLoaded  out  1  &CtxValid
- CfgErr  out  1  1-cycle pulse on frame error
- Overriding  out  1  an override is applied to Qout this cycle
- ActiveCtx  out  $clog2(NCTX)  context driving Qout; valid when Overriding

Behaviour:
- Reset: Qout=0, CtxValid=0, CfgErr=0, Overriding=0, ActiveCtx=0, loader in IDLE, hold counter 0, all context regs 0.
- Frame layout: CID ($clog2(NCTX)) | MASK (N) | CONST (N) | HOLD (HOLD_W) | P (1). PAY_W = 2N+HOLD_W.
- Only bits with BitStreamValid=1 are consumed. Gaps of any length are allowed.
- Loader FSM:
  - IDLE→HDR on the first valid bit.
  - HDR collects CID, then goes to PAY.
  - PAY collects PAY_W bits; then PAR takes 1 bit; then CHECK.
- Decrypt: payload bit k (k=0 is the first payload bit) is XORed with DECRYPT_KEY[KEY_W-1-(k mod KEY_W)]. CID and P are not encrypted.
- CHECK: even parity over decrypted payload XOR P.
  - Pass → COMMIT.
  - Fail → CfgErr pulse, back to IDLE, shadow discarded.
- COMMIT: write shadow to context CID, set CtxValid[CID], then IDLE.
  - If CID == ActiveCtx and Overriding=1, COMMIT stalls until that no longer holds (no tearing).
- A CID ≥ NCTX is treated as a parity failure.
- Valid bits arriving in CHECK/COMMIT are dropped and pulse CfgErr. The in-flight frame is unaffected.
- Runtime selection: a context is eligible if Trig[i]=1 and CtxValid[i]=1. The lowest eligible index wins and preempts immediately.
- Hold: when no context is eligible and the previous cycle was overriding with an eligible trigger, the hold counter loads HOLD of ActiveCtx.
  - Overriding stays 1 while counter > 0; counter decrements each cycle.
  - A new eligible trigger during hold cancels the hold and re-selects.
- Qout(t+1) = Overriding_next ? (MASK & CONST) | (~MASK & Qin(t)) : Qin(t). Latency is 1 cycle.
- Trig falls at t with HOLD=H → override applied on Qout for outputs t+1..t+H; passthrough from t+H+1. With H=0, passthrough from t+1.
- GlobalFruEn=0 → passthrough next cycle, Overriding=0, hold counter cleared. Loading continues normally.
- rst mid-frame discards the partial frame and clears all contexts.

Optional Feature:
- FRU_MC_OTP_EN defined: once CtxValid[i]=1, any further frame targeting i is fully received, then rejected with a CfgErr pulse at CHECK. Context i is unchanged.
- Undefined: contexts are freely reprogrammable.

Decomposition:
- Package fru_mc_pkg holds:
  - loader state enum (IDLE, HDR, PAY, PAR, CHECK, COMMIT)
  - context record typedef {mask, const, hold}
  - PAY_W and CID_W localparam functions
- Sub-module fru_mc_loader: serial FSM, decrypt, parity. It outputs a commit strobe, CID and the decoded record, and takes a stall input.
- Top level holds the context regs, selection, hold and output mux.

Test Plan:
- Load ctx1 with MASK=0x0000_00FF, CONST=0xA5, HOLD=3; Qin=0x1234_5678; Trig[1]=1 for 2 cycles → Qout=0x1234_56A5 from the next edge, held 3 cycles after Trig falls, then 0x1234_5678. ActiveCtx=1.
- Frame with flipped parity bit → CfgErr pulse 1 cycle, CtxValid unchanged. Random BitStreamValid gaps give the identical result.
- ctx0 and ctx2 loaded; Trig=4'b0100, then Trig=4'b0101 → ActiveCtx 2→0 on the next cycle, ctx0 const applied.
- Reload ctx1 while ctx1 is overriding → COMMIT stalls; new values appear only after Trig[1] falls and hold expires. Qout is never a mix of old and new.
- GlobalFruEn=0 with Trig[1]=1 → Qout=Qin one cycle later, Overriding=0. Assert rst mid-frame → all outputs return to reset values.
- With FRU_MC_OTP_EN: second frame to ctx1 → CfgErr pulse, ctx1 retains its first values. Without the macro, ctx1 updates.

Source files
------------

// File: rtl/fru_mc_pkg.sv
// -----------------------------------------------------------------------------
// fru_mc_pkg
// Shared types and helpers for the multi-context FRU (fru_mc) and its serial
// configuration loader (fru_mc_loader).
//
// Contents:
//   FRU_N, FRU_HOLD_W : default controlled-set width and hold-counter width.
//                       The context record below is sized by these constants.
//                       A build with a different N or HOLD_W must change them
//                       here as well as the module parameters.
//   ld_state_t        : loader FSM states.
//   ctx_rec_t         : one override context {mask, value, hold}. The field
//                       order matches the decrypted payload order, MSB first.
//   pay_w()/cid_w()   : payload and context-id field widths.
// -----------------------------------------------------------------------------
package fru_mc_pkg;

  localparam int FRU_N      = 32;
  localparam int FRU_HOLD_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    PAR,
    CHECK,
    COMMIT
  } ld_state_t;

  // "value" carries the override constant; "const" is a reserved word.
  typedef struct packed {
    logic [FRU_N-1:0]      mask;
    logic [FRU_N-1:0]      value;
    logic [FRU_HOLD_W-1:0] hold;
  } ctx_rec_t;

  // Encrypted payload width: MASK + CONST + HOLD.
  function automatic int pay_w(input int n, input int hold_w);
    return 2 * n + hold_w;
  endfunction

  // Context-id field width. Never narrower than one bit.
  function automatic int cid_w(input int nctx);
    return (nctx > 1) ? $clog2(nctx) : 1;
  endfunction

endpackage

// File: rtl/fru_mc_loader.sv
// -----------------------------------------------------------------------------
// fru_mc_loader
// Serial configuration loader for fru_mc. Receives frames MSB first:
//   CID | MASK | CONST | HOLD | P
// Only bits with bit_valid=1 are consumed, so gaps of any length are allowed.
// The payload (MASK|CONST|HOLD) is XOR-decrypted with a repeating keystream
// taken from DECRYPT_KEY, MSB first. CID and P are sent in the clear.
// P makes the parity of the decrypted payload even.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bit_in     : serial configuration bit
//   bit_valid  : qualifies bit_in
//   stall      : holds the frame in COMMIT while the target context drives
//                the output
//   ctx_valid  : committed flags of all contexts (used only when the
//                one-time-programmable option is enabled)
//   commit     : one-cycle write strobe for context "cid" with record "rec"
//   cid        : target context of the frame
//   rec        : decrypted record
//   cfg_err    : one-cycle pulse on a rejected frame or a dropped bit
//
// Build option: FRU_MC_OTP_EN. When it is defined, a frame aimed at a context
// that already holds a committed configuration is received completely and
// then rejected at CHECK.
// -----------------------------------------------------------------------------
module fru_mc_loader
  import fru_mc_pkg::*;
#(
  parameter int               N           = FRU_N,
  parameter int               NCTX        = 4,
  parameter int               HOLD_W      = FRU_HOLD_W,
  parameter int               KEY_W       = 32,
  parameter logic [KEY_W-1:0] DECRYPT_KEY = 32'hDEAD_BEEF,
  localparam int              CID_W       = cid_w(NCTX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             stall,
  input  logic [NCTX-1:0]  ctx_valid,
  output logic             commit,
  output logic [CID_W-1:0] cid,
  output ctx_rec_t         rec,
  output logic             cfg_err
);

  localparam int PAY_W  = pay_w(N, HOLD_W);
  localparam int CNT_W  = $clog2(PAY_W + 1);
  localparam int KIDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  ld_state_t         state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [KIDX_W-1:0] kidx_reg;
  logic [CID_W-1:0]  cid_reg;
  logic [PAY_W-1:0]  pay_reg;
  logic              par_reg;
  logic              par_ok_reg;
  logic              cfg_err_reg;

  logic              dec_bit;
  logic              otp_block;
  logic              reject;

  // Keystream position counts down from the key MSB and wraps every KEY_W
  // payload bits.
  assign dec_bit = bit_in ^ DECRYPT_KEY[kidx_reg];

`ifdef FRU_MC_OTP_EN
  assign otp_block = ctx_valid[cid_reg];
`else
  assign otp_block = 1'b0 & (|ctx_valid);
`endif

  // An out-of-range context id is handled like a parity failure.
  assign reject = !par_ok_reg || (int'(cid_reg) >= NCTX) || otp_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      kidx_reg    <= KIDX_W'(KEY_W - 1);
      cid_reg     <= '0;
      pay_reg     <= '0;
      par_reg     <= 1'b0;
      par_ok_reg  <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The first valid bit is already the CID MSB.
          if (bit_valid) begin
            cid_reg  <= CID_W'(bit_in);
            kidx_reg <= KIDX_W'(KEY_W - 1);
            par_reg  <= 1'b0;
            if (CID_W == 1) begin
              cnt_reg   <= '0;
              state_reg <= PAY;
            end else begin
              cnt_reg   <= CNT_W'(1);
              state_reg <= HDR;
            end
          end
        end

        HDR: begin
          if (bit_valid) begin
            cid_reg <= CID_W'({cid_reg, bit_in});
            if (cnt_reg == CNT_W'(CID_W - 1)) begin
              cnt_reg   <= '0;
              state_reg <= PAY;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end

        PAY: begin
          if (bit_valid) begin
            pay_reg  <= {pay_reg[PAY_W-2:0], dec_bit};
            par_reg  <= par_reg ^ dec_bit;
            kidx_reg <= (kidx_reg == '0) ? KIDX_W'(KEY_W - 1) : kidx_reg - KIDX_W'(1);
            if (cnt_reg == CNT_W'(PAY_W - 1)) begin
              state_reg <= PAR;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end

        PAR: begin
          if (bit_valid) begin
            par_ok_reg <= ~(par_reg ^ bit_in);
            state_reg  <= CHECK;
          end
        end

        CHECK: begin
          // Any valid bit seen here is dropped and flagged; the frame in
          // flight is judged on its own merits.
          cfg_err_reg <= bit_valid | reject;
          state_reg   <= reject ? IDLE : COMMIT;
        end

        COMMIT: begin
          cfg_err_reg <= bit_valid;
          if (!stall) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // The strobe is decoded from the current state and the live stall so the
  // write lands on exactly the edge the stall is seen low. A registered
  // strobe would write one cycle late, when the context may already have
  // been re-selected.
  assign commit     = (state_reg == COMMIT) && !stall;
  assign cid        = cid_reg;
  assign rec.mask   = pay_reg[PAY_W-1 -: N];
  assign rec.value  = pay_reg[HOLD_W +: N];
  assign rec.hold   = pay_reg[HOLD_W-1:0];
  assign cfg_err    = cfg_err_reg;

endmodule

// File: rtl/fru_mc.sv
// -----------------------------------------------------------------------------
// fru_mc
// Multi-context field-replaceable-unit patcher. It sits between the trigger
// outputs and the patched signal set. NCTX contexts each hold {mask, value,
// hold}. Each context is loaded through the encrypted serial loader
// (fru_mc_loader). The lowest-indexed context whose trigger is high and whose
// configuration is committed drives the registered output:
//   Qout <= (mask & value) | (~mask & Qin)   while overriding
//   Qout <= Qin                              otherwise
// When every trigger drops, the last active context keeps overriding for
// "hold" more output cycles.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   BitStreamSerialIn  : serial configuration bit, MSB first
//   BitStreamValid     : qualifies BitStreamSerialIn
//   GlobalFruEn        : 0 forces passthrough and cancels any hold
//   Trig[NCTX]         : Trig[i] requests context i
//   Qin[N]             : controlled signal set input
//   Qout[N]            : patched output, registered (1-cycle latency)
//   CtxValid[NCTX]     : context i holds a committed configuration
//   BitstreamLoaded    : all contexts committed
//   CfgErr             : one-cycle pulse on a configuration error
//   Overriding         : Qout currently carries an override
//   ActiveCtx          : context behind the current override
//
// Build option: FRU_MC_OTP_EN (one-time-programmable contexts, in the loader).
// -----------------------------------------------------------------------------
module fru_mc
  import fru_mc_pkg::*;
#(
  parameter int               N           = FRU_N,
  parameter int               NCTX        = 4,
  parameter int               HOLD_W      = FRU_HOLD_W,
  parameter int               KEY_W       = 32,
  parameter logic [KEY_W-1:0] DECRYPT_KEY = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      BitStreamSerialIn,
  input  logic                      BitStreamValid,
  input  logic                      GlobalFruEn,
  input  logic [NCTX-1:0]           Trig,
  input  logic [N-1:0]              Qin,
  output logic [N-1:0]              Qout,
  output logic [NCTX-1:0]           CtxValid,
  output logic                      BitstreamLoaded,
  output logic                      CfgErr,
  output logic                      Overriding,
  output logic [$clog2(NCTX)-1:0]   ActiveCtx
);

  localparam int CID_W = cid_w(NCTX);

  // Context storage.
  ctx_rec_t         ctx_reg [NCTX];
  logic [NCTX-1:0]  ctx_valid_reg;

  // Runtime selection state.
  logic [N-1:0]      qout_reg;
  logic              ovr_reg;
  logic [CID_W-1:0]  active_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              trig_prev_reg;

  logic [N-1:0]      qout_next;
  logic              ovr_next;
  logic [CID_W-1:0]  active_next;
  logic [HOLD_W-1:0] hold_next;
  logic              trig_next;

  logic [NCTX-1:0]   elig;
  logic [CID_W-1:0]  sel;
  ctx_rec_t          rec_sel;
  logic [HOLD_W-1:0] hold_load;

  // Loader interface.
  logic              ld_commit;
  logic [CID_W-1:0]  ld_cid;
  ctx_rec_t          ld_rec;
  logic              ld_stall;
  logic              ld_cfg_err;
  logic [NCTX-1:0]   wr_en;

  // A frame for the context currently on the output waits, so Qout never
  // mixes an old and a new record inside one override.
  assign ld_stall = ovr_reg && (active_reg == ld_cid);

  fru_mc_loader #(
    .N           (N),
    .NCTX        (NCTX),
    .HOLD_W      (HOLD_W),
    .KEY_W       (KEY_W),
    .DECRYPT_KEY (DECRYPT_KEY)
  ) u_loader (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (BitStreamSerialIn),
    .bit_valid (BitStreamValid),
    .stall     (ld_stall),
    .ctx_valid (ctx_valid_reg),
    .commit    (ld_commit),
    .cid       (ld_cid),
    .rec       (ld_rec),
    .cfg_err   (ld_cfg_err)
  );

  for (genvar gi = 0; gi < NCTX; gi++) begin : g_wr
    assign wr_en[gi] = ld_commit && (ld_cid == CID_W'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCTX; i++) begin
        ctx_reg[i] <= '0;
      end
      ctx_valid_reg <= '0;
    end else begin
      for (int i = 0; i < NCTX; i++) begin
        if (wr_en[i]) begin
          ctx_reg[i]       <= ld_rec;
          ctx_valid_reg[i] <= 1'b1;
        end
      end
    end
  end

  // Selection, hold and output mux.
  // The hold counter stores the number of override cycles still owed after
  // the current one. It is loaded with HOLD-1 on the cycle the triggers drop,
  // which gives exactly HOLD overridden outputs after the drop.
  always_comb begin
    elig        = Trig & ctx_valid_reg;
    sel         = '0;
    for (int i = NCTX - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel = CID_W'(i);
      end
    end

    ovr_next    = 1'b0;
    active_next = active_reg;
    hold_next   = '0;
    trig_next   = 1'b0;
    hold_load   = ctx_reg[active_reg].hold;

    if (!GlobalFruEn) begin
      ovr_next = 1'b0;
    end else if (|elig) begin
      ovr_next    = 1'b1;
      active_next = sel;
      trig_next   = 1'b1;
    end else if (trig_prev_reg) begin
      if (hold_load != '0) begin
        ovr_next  = 1'b1;
        hold_next = hold_load - HOLD_W'(1);
      end
    end else if (ovr_reg && (hold_cnt_reg != '0)) begin
      ovr_next  = 1'b1;
      hold_next = hold_cnt_reg - HOLD_W'(1);
    end

    rec_sel   = ctx_reg[active_next];
    qout_next = ovr_next ? ((rec_sel.mask & rec_sel.value) | (~rec_sel.mask & Qin)) : Qin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qout_reg      <= '0;
      ovr_reg       <= 1'b0;
      active_reg    <= '0;
      hold_cnt_reg  <= '0;
      trig_prev_reg <= 1'b0;
    end else begin
      qout_reg      <= qout_next;
      ovr_reg       <= ovr_next;
      active_reg    <= active_next;
      hold_cnt_reg  <= hold_next;
      trig_prev_reg <= trig_next;
    end
  end

  assign Qout            = qout_reg;
  assign CtxValid        = ctx_valid_reg;
  assign BitstreamLoaded = &ctx_valid_reg;
  assign CfgErr          = ld_cfg_err;
  assign Overriding      = ovr_reg;
  assign ActiveCtx       = active_reg;

endmodule
